stack_ctrl: RTL



---
 rtl/stack_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stack_ctrl.sv
// PUSH/POP sequencer: reads SP from the register file, checks stack bounds,
// moves data between the register file and data memory, then reports completion.
module stack_ctrl #(
  parameter int WIDTH       = 8,
  parameter int ADDR        = 2,
  parameter int SP_IDX      = 3,
  parameter int STACK_BASE  = 255,
  parameter int STACK_LIMIT = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [ADDR-1:0]  cmd_dst,
  output logic             rf_rd_en,
  output logic [ADDR-1:0]  rf_r_add_a,
  input  logic [WIDTH-1:0] rf_rd_data_a,
  input  logic             rf_rd_data_vld,
  output logic             rf_wr_en,
  output logic [ADDR-1:0]  rf_w_add,
  output logic [WIDTH-1:0] rf_wr_data,
  output logic             mem_wr_en,
  output logic             mem_rd_en,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wr_data,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [ADDR-1:0]  SP_ADDR = ADDR'(SP_IDX);
  localparam logic [WIDTH-1:0] BASE_V  = WIDTH'(STACK_BASE);
  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(STACK_LIMIT);

  localparam logic [1:0] CODE_NONE      = 2'b00;
  localparam logic [1:0] CODE_OVERFLOW  = 2'b01;
  localparam logic [1:0] CODE_UNDERFLOW = 2'b10;
  localparam logic [1:0] CODE_ILLEGAL   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_SP_RD, S_SP_WAIT, S_PUSH_WR, S_POP_RD,
    S_POP_WAIT, S_POP_WB, S_SP_WB, S_DONE, S_ERR
  } state_t;

  state_t           state, state_nx;
  logic             op_q;
  logic [WIDTH-1:0] data_q;
  logic [ADDR-1:0]  dst_q;
  logic [WIDTH-1:0] sp_q;
  logic [WIDTH-1:0] pop_q;
  logic [1:0]       chk_code;

  // Bounds/destination check against the SP value arriving from the register file.
  always_comb begin
    chk_code = CODE_NONE;
    if (!op_q) begin
      if (rf_rd_data_a == LIMIT_V) chk_code = CODE_OVERFLOW;
    end else if (rf_rd_data_a == BASE_V) begin
      chk_code = CODE_UNDERFLOW;
    end else if (dst_q == SP_ADDR) begin
      chk_code = CODE_ILLEGAL;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (cmd_valid) state_nx = S_SP_RD;
      S_SP_RD:    state_nx = S_SP_WAIT;
      S_SP_WAIT: begin
        if (rf_rd_data_vld) begin
          if (chk_code != CODE_NONE) state_nx = S_ERR;
          else if (op_q)             state_nx = S_POP_RD;
          else                       state_nx = S_PUSH_WR;
        end
      end
      S_PUSH_WR:  state_nx = S_DONE;
      S_POP_RD:   state_nx = S_POP_WAIT;
      S_POP_WAIT: state_nx = S_POP_WB;
      S_POP_WB:   state_nx = S_SP_WB;
      S_SP_WB:    state_nx = S_DONE;
      S_DONE:     state_nx = S_IDLE;
      S_ERR:      state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      op_q     <= 1'b0;
      data_q   <= '0;
      dst_q    <= '0;
      sp_q     <= '0;
      pop_q    <= '0;
      err_code <= CODE_NONE;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && cmd_valid) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        dst_q  <= cmd_dst;
      end
      if (state == S_SP_WAIT && rf_rd_data_vld) sp_q <= rf_rd_data_a;
      if (state == S_POP_WAIT) pop_q <= mem_rd_data;
      // err_code only changes when a command finishes, so it holds between commands.
      if (state_nx == S_ERR)       err_code <= chk_code;
      else if (state_nx == S_DONE) err_code <= CODE_NONE;
    end
  end

  always_comb begin
    cmd_ready   = (state == S_IDLE);
    rf_r_add_a  = SP_ADDR;
    rf_rd_en    = 1'b0;
    rf_wr_en    = 1'b0;
    rf_w_add    = '0;
    rf_wr_data  = '0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    done        = 1'b0;
    err         = 1'b0;
    unique case (state)
      S_SP_RD: rf_rd_en = 1'b1;
      S_PUSH_WR: begin
        mem_wr_en   = 1'b1;
        mem_addr    = sp_q;
        mem_wr_data = data_q;
        rf_wr_en    = 1'b1;
        rf_w_add    = SP_ADDR;
        rf_wr_data  = sp_q - WIDTH'(1);
      end
      S_POP_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = sp_q + WIDTH'(1);
      end
      S_POP_WB: begin
        rf_wr_en   = 1'b1;
        rf_w_add   = dst_q;
        rf_wr_data = pop_q;
      end
      S_SP_WB: begin
        rf_wr_en   = 1'b1;
        rf_w_add   = SP_ADDR;
        rf_wr_data = sp_q + WIDTH'(1);
      end
      S_DONE: done = 1'b1;
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
